// File: rtl/fwd_pkg.sv
// Shared types and constants for the ID->EX operand forwarding / load-use stall unit.
package fwd_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwdState_e;

  localparam int         SEL_RF = 0;
  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic int selWidth(input int nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational priority match of one source operand against all forwarding sources.
// Lowest source index (youngest) wins; register x0 always reads as zero.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3,
  parameter int SELW = selWidth(NFWD)
) (
  input  logic [4:0]           rs,
  input  logic                 used,
  input  logic [XLEN-1:0]      rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]      data,
  output logic [SELW-1:0]      sel,
  output logic                 pend
);

  // Scan oldest to youngest so the youngest matching source overwrites the rest.
  always_comb begin
    data = rdata;
    sel  = SELW'(SEL_RF);
    pend = 1'b0;
    if (rs == REG_X0) begin
      data = '0;
    end else if (used) begin
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_rd[i*5 +: 5] != REG_X0) && (fwd_rd[i*5 +: 5] == rs)) begin
          data = fwd_data[i*XLEN +: XLEN];
          sel  = SELW'(i + 1);
          pend = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit at the ID->EX boundary.
// Optional event counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NRD      = 2,
  parameter int NFWD     = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [NRD*5-1:0]                id_rs,
  input  logic [NRD-1:0]                  id_rs_used,
  input  logic [NRD*XLEN-1:0]             id_rdata,
  input  logic [NFWD-1:0]                 fwd_we,
  input  logic [NFWD*5-1:0]               fwd_rd,
  input  logic [NFWD-1:0]                 fwd_pending,
  input  logic [NFWD*XLEN-1:0]            fwd_data,
  input  logic                            flush,
  input  logic                            hold,
  output logic                            stall,
  output logic                            ex_valid,
  output logic [NRD*XLEN-1:0]             ex_op,
  output logic [NRD*$clog2(NFWD+1)-1:0]   ex_sel,
  output logic [31:0]                     stat_fwd,
  output logic [31:0]                     stat_stall
);

  localparam int              SELW     = selWidth(NFWD);
  localparam int              CNTW     = ($clog2(LOAD_LAT) > 2) ? $clog2(LOAD_LAT) : 2;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LOAD_LAT - 1);

  logic [NRD*XLEN-1:0] resData;
  logic [NRD*SELW-1:0] resSel;
  logic [NRD-1:0]      resPend;
  fwdState_e           state, stateNext;
  logic [CNTW-1:0]     cnt, cntNext;
  logic                hazard;
  logic                forced;

  for (genvar p = 0; p < NRD; p++) begin : gMatch
    fwd_match #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) uMatch (
      .rs          (id_rs[p*5 +: 5]),
      .used        (id_rs_used[p]),
      .rdata       (id_rdata[p*XLEN +: XLEN]),
      .fwd_we      (fwd_we),
      .fwd_rd      (fwd_rd),
      .fwd_pending (fwd_pending),
      .fwd_data    (fwd_data),
      .data        (resData[p*XLEN +: XLEN]),
      .sel         (resSel[p*SELW +: SELW]),
      .pend        (resPend[p])
    );
  end

  assign hazard = id_valid && (|resPend);
  // The final STALL cycle (cnt==0) behaves like RUN so a hazard costs exactly LOAD_LAT cycles.
  assign forced = (state == STALL) && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (flush) begin
      stateNext = RUN;
      cntNext   = '0;
    end else if (!hold) begin
      if (forced) begin
        cntNext = cnt - CNTW'(1);
      end else if (hazard) begin
        stateNext = STALL;
        cntNext   = CNT_LOAD;
      end else begin
        stateNext = RUN;
        cntNext   = '0;
      end
    end
  end

  always_comb begin
    stall = !rst && (forced || hazard);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_sel   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!hold) begin
      if (stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_valid;
        ex_op    <= resData;
        ex_sel   <= resSel;
      end
    end
  end

`ifdef FWD_STATS_EN
  localparam int CW = $clog2(NRD + 1);

  logic [CW-1:0] fwdCount;
  logic [32:0]   fwdSum;
  logic [31:0]   statFwd, statStall;

  always_comb begin
    fwdCount = '0;
    for (int p = 0; p < NRD; p++) begin
      if (resSel[p*SELW +: SELW] != SELW'(SEL_RF)) fwdCount = fwdCount + CW'(1);
    end
  end

  assign fwdSum = {1'b0, statFwd} + 33'(fwdCount);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statFwd   <= '0;
      statStall <= '0;
    end else begin
      if (!flush && !hold && !stall && id_valid) statFwd <= fwdSum[32] ? '1 : fwdSum[31:0];
      if (stall && !hold && (statStall != '1)) statStall <= statStall + 32'd1;
    end
  end

  assign stat_fwd   = statFwd;
  assign stat_stall = statStall;
`else
  assign stat_fwd   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit: directed scenarios then randomized traffic
// against a cycle-level behavioural model.
module tb_fwd_hazard_unit;

  localparam int LOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [63:0] id_rdata;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_rd;
  logic [2:0]  fwd_pending;
  logic [95:0] fwd_data;
  logic        flush;
  logic        hold;
  logic        stall;
  logic        ex_valid;
  logic [63:0] ex_op;
  logic [3:0]  ex_sel;
  logic [31:0] stat_fwd;
  logic [31:0] stat_stall;

  fwd_hazard_unit #(.XLEN(32), .NRD(2), .NFWD(3), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rdata(id_rdata), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_pending(fwd_pending),
    .fwd_data(fwd_data), .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_sel(ex_sel), .stat_fwd(stat_fwd), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        exValid;
    logic [63:0] exOp;
    logic [3:0]  exSel;
    logic [31:0] statFwd;
    logic [31:0] statStall;
  } exp_t;

  exp_t expQ[$];
  exp_t monRec;

  int checks = 0;
  int passes = 0;

  // Reference model: forced stall cycles left, and the EX register contents it predicts.
  int          remaining = 0;
  logic        mValid = 1'b0;
  logic [31:0] mOp [2] = '{32'h0, 32'h0};
  int          mSel [2] = '{0, 0};
  longint      mStatFwd = 0;
  longint      mStatStall = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic stepModel();
    exp_t        e;
    int          sel [2];
    logic [31:0] val [2];
    bit          pend [2];
    logic [4:0]  rs;
    bit          hazard;
    bit          stallNow;
    int          nFwd;
    hazard   = 1'b0;
    stallNow = 1'b0;
    if (rst) begin
      remaining  = 0;
      mValid     = 1'b0;
      mOp        = '{32'h0, 32'h0};
      mSel       = '{0, 0};
      mStatFwd   = 0;
      mStatStall = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rs      = id_rs[p*5 +: 5];
        sel[p]  = 0;
        val[p]  = (rs == 5'd0) ? 32'h0 : id_rdata[p*32 +: 32];
        pend[p] = 1'b0;
        if (rs != 5'd0 && id_rs_used[p]) begin
          for (int i = 0; i < 3; i++) begin
            if (fwd_we[i] && fwd_rd[i*5 +: 5] == rs) begin
              sel[p]  = i + 1;
              val[p]  = fwd_data[i*32 +: 32];
              pend[p] = fwd_pending[i];
              break;
            end
          end
        end
      end
      hazard   = id_valid && (pend[0] || pend[1]);
      stallNow = (remaining > 0) || hazard;
    end

    e.stall   = stallNow;
    e.exValid = mValid;
    e.exOp    = {mOp[1], mOp[0]};
    e.exSel   = {2'(mSel[1]), 2'(mSel[0])};
`ifdef FWD_STATS_EN
    e.statFwd   = mStatFwd[31:0];
    e.statStall = mStatStall[31:0];
`else
    e.statFwd   = 32'h0;
    e.statStall = 32'h0;
`endif
    expQ.push_back(e);

    if (!rst) begin
      if (stallNow && !hold && mStatStall < 64'hFFFF_FFFF) mStatStall++;
      if (flush) begin
        mValid    = 1'b0;
        remaining = 0;
      end else if (!hold) begin
        if (stallNow) begin
          mValid = 1'b0;
        end else begin
          mValid = id_valid;
          mOp    = val;
          mSel   = sel;
          if (id_valid) begin
            nFwd = int'(sel[0] != 0) + int'(sel[1] != 0);
            mStatFwd = mStatFwd + nFwd;
            if (mStatFwd > 64'hFFFF_FFFF) mStatFwd = 64'hFFFF_FFFF;
          end
        end
        if (remaining > 0) remaining--;
        else if (hazard) remaining = LOAD_LAT - 1;
      end
    end
  endtask

  task automatic applyStimulus();
    stepModel();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    id_valid    = 1'b0;
    id_rs       = {5'd2, 5'd1};
    id_rs_used  = 2'b00;
    id_rdata    = {32'h1234_0002, 32'h1234_0001};
    fwd_we      = 3'b000;
    fwd_rd      = '0;
    fwd_pending = 3'b000;
    fwd_data    = '0;
    flush       = 1'b0;
    hold        = 1'b0;
  endtask

  task automatic setLoadHazard();
    setIdle();
    id_valid    = 1'b1;
    id_rs       = {5'd7, 5'd3};
    id_rs_used  = 2'b11;
    id_rdata    = {32'h99, 32'h33};
    fwd_we      = 3'b001;
    fwd_rd      = {5'd0, 5'd0, 5'd7};
    fwd_pending = 3'b001;
  endtask

  task automatic setLoadInMem();
    fwd_we      = 3'b010;
    fwd_rd      = {5'd0, 5'd7, 5'd0};
    fwd_data    = {32'h0, 32'h77, 32'h0};
    fwd_pending = 3'b000;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle away from the clock edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monRec = expQ.pop_front();
      checkOutput("sb_stall", 64'(stall), 64'(monRec.stall));
      checkOutput("sb_ex_valid", 64'(ex_valid), 64'(monRec.exValid));
      if (monRec.exValid) begin
        checkOutput("sb_ex_op", ex_op, monRec.exOp);
        checkOutput("sb_ex_sel", 64'(ex_sel), 64'(monRec.exSel));
      end
      checkOutput("sb_stat_fwd", 64'(stat_fwd), 64'(monRec.statFwd));
      checkOutput("sb_stat_stall", 64'(stat_stall), 64'(monRec.statStall));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stallCycles;
    rst = 1'b1;
    setIdle();
    tick();

    // Reset state
    applyStimulus();
    checkOutput("rst_stall", 64'(stall), 64'h0);
    checkOutput("rst_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("rst_ex_op", ex_op, 64'h0);
    checkOutput("rst_ex_sel", 64'(ex_sel), 64'h0);
    checkOutput("rst_stat_fwd", 64'(stat_fwd), 64'h0);
    checkOutput("rst_stat_stall", 64'(stat_stall), 64'h0);
    tick();
    rst = 1'b0;

    // No hazard, register-file operands
    setIdle();
    id_valid   = 1'b1;
    id_rs      = {5'd4, 5'd3};
    id_rs_used = 2'b11;
    id_rdata   = {32'h22, 32'h11};
    applyStimulus();
    checkOutput("nohaz_stall", 64'(stall), 64'h0);
    tick();
    checkOutput("nohaz_valid", 64'(ex_valid), 64'h1);
    checkOutput("nohaz_op", ex_op, {32'h22, 32'h11});
    checkOutput("nohaz_sel", 64'(ex_sel), 64'h0);

    // Priority: youngest source wins, then the older one once the youngest drops out
    id_rs    = {5'd4, 5'd5};
    fwd_we   = 3'b101;
    fwd_rd   = {5'd5, 5'd0, 5'd5};
    fwd_data = {32'hCCCC, 32'h0, 32'hAAAA};
    applyStimulus();
    tick();
    checkOutput("prio_op0_young", 64'(ex_op[31:0]), 64'hAAAA);
    checkOutput("prio_sel0_young", 64'(ex_sel[1:0]), 64'h1);
    fwd_we = 3'b100;
    applyStimulus();
    tick();
    checkOutput("prio_op0_wb", 64'(ex_op[31:0]), 64'hCCCC);
    checkOutput("prio_sel0_wb", 64'(ex_sel[1:0]), 64'h3);

    // x0 is never forwarded and never stalls
    id_rs       = {5'd4, 5'd0};
    id_rdata    = {32'h22, 32'h55};
    fwd_we      = 3'b001;
    fwd_rd      = '0;
    fwd_data    = {32'h0, 32'h0, 32'hDEAD};
    fwd_pending = 3'b001;
    applyStimulus();
    checkOutput("x0_stall", 64'(stall), 64'h0);
    tick();
    checkOutput("x0_op0", 64'(ex_op[31:0]), 64'h0);
    checkOutput("x0_sel0", 64'(ex_sel[1:0]), 64'h0);

    // Load-use from a clean reset: LOAD_LAT stall cycles, then MEM forward
    setIdle();
    rst = 1'b1;
    applyStimulus();
    tick();
    rst = 1'b0;
    setLoadHazard();
    applyStimulus();
    checkOutput("lu_stall_c0", 64'(stall), 64'h1);
    tick();
    checkOutput("lu_bubble_c0", 64'(ex_valid), 64'h0);
    applyStimulus();
    checkOutput("lu_stall_c1", 64'(stall), 64'h1);
    tick();
    checkOutput("lu_bubble_c1", 64'(ex_valid), 64'h0);
    setLoadInMem();
    applyStimulus();
    checkOutput("lu_stall_done", 64'(stall), 64'h0);
    tick();
    checkOutput("lu_valid", 64'(ex_valid), 64'h1);
    checkOutput("lu_op1", 64'(ex_op[63:32]), 64'h77);
    checkOutput("lu_sel1", 64'(ex_sel[3:2]), 64'h2);
`ifdef FWD_STATS_EN
    checkOutput("lu_stat_fwd", 64'(stat_fwd), 64'h1);
    checkOutput("lu_stat_stall", 64'(stat_stall), 64'h2);
`else
    checkOutput("lu_stat_fwd", 64'(stat_fwd), 64'h0);
    checkOutput("lu_stat_stall", 64'(stat_stall), 64'h0);
`endif

    // Hold for three cycles in the middle of a stall stretches it by three
    setLoadHazard();
    stallCycles = 0;
    for (int c = 0; c < 6; c++) begin
      hold = (c >= 1 && c <= 3);
      if (c == 5) setLoadInMem();
      applyStimulus();
      if (stall) stallCycles++;
      tick();
    end
    hold = 1'b0;
    checkOutput("hold_len", 64'(stallCycles), 64'(LOAD_LAT + 3));

    // Flush during a stall returns to RUN
    setIdle();
    applyStimulus();
    tick();
    setLoadHazard();
    applyStimulus();
    tick();
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush_stall", 64'(stall), 64'h1);
    tick();
    checkOutput("flush_bubble", 64'(ex_valid), 64'h0);
    setIdle();
    applyStimulus();
    checkOutput("flush_run", 64'(stall), 64'h0);
    tick();
    checkOutput("flush_idle_valid", 64'(ex_valid), 64'h0);

    // Asynchronous reset in the middle of a stall
    setLoadHazard();
    applyStimulus();
    tick();
    rst = 1'b1;
    applyStimulus();
    checkOutput("arst_stall", 64'(stall), 64'h0);
    checkOutput("arst_valid", 64'(ex_valid), 64'h0);
    checkOutput("arst_op", ex_op, 64'h0);
    checkOutput("arst_sel", 64'(ex_sel), 64'h0);
    tick();
    rst = 1'b0;
    setIdle();
    applyStimulus();
    checkOutput("arst_run", 64'(stall), 64'h0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < 2; p++) begin
        id_rs[p*5 +: 5]     = 5'($urandom_range(0, 7));
        id_rs_used[p]       = ($urandom_range(0, 5) != 0);
        id_rdata[p*32 +: 32] = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        fwd_we[i]            = ($urandom_range(0, 2) != 0);
        fwd_rd[i*5 +: 5]     = 5'($urandom_range(0, 7));
        fwd_pending[i]       = ($urandom_range(0, 4) == 0);
        fwd_data[i*32 +: 32] = $urandom;
      end
      flush = ($urandom_range(0, 24) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      applyStimulus();
      tick();
    end

    rst = 1'b0;
    setIdle();
    checkOutput("queue_drained", 64'(expQ.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
